// File: rtl/prefetch_queue.sv
// ---------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch buffer sitting between the memory-interface fetch
// client slot and decode. It reads sequential instruction words on its own
// into a DEPTH-entry FIFO of {pc, inst} pairs. The head entry is presented to
// decode through a valid/take handshake. A redirect from execute flushes the
// queue and restarts fetching at the new pc.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-high reset
//   i_flush        one-cycle redirect pulse from execute
//   i_flush_pc     redirect target, sampled while i_flush=1
//   o_mem_req      fetch request to the memory interface
//   o_mem_addr     word-aligned byte address of the requested word
//   i_mem_data_in  read data, valid while i_mem_ready=1
//   i_mem_ready    single-cycle completion strobe
//   o_inst_valid   head entry present
//   o_inst_out     head instruction word
//   o_inst_pc      address of the head instruction
//   i_inst_take    decode consumes the head this cycle
// ---------------------------------------------------------------------------
module prefetch_queue #(
    parameter int                 M_WIDTH  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [M_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic [M_WIDTH-1:0] i_flush_pc,
    output logic               o_mem_req,
    output logic [M_WIDTH-1:0] o_mem_addr,
    input  logic [M_WIDTH-1:0] i_mem_data_in,
    input  logic               i_mem_ready,
    output logic               o_inst_valid,
    output logic [M_WIDTH-1:0] o_inst_out,
    output logic [M_WIDTH-1:0] o_inst_pc,
    input  logic               i_inst_take
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [M_WIDTH-1:0] WORD_STEP = M_WIDTH'(M_WIDTH / 8);

    // DRAIN waits out a request whose target was invalidated by a redirect.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetchState_t;

    fetchState_t r_state;
    fetchState_t w_nextState;

    logic [M_WIDTH-1:0] r_pcMem   [DEPTH];
    logic [M_WIDTH-1:0] r_instMem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [M_WIDTH-1:0] r_fetchAddr;
    logic [M_WIDTH-1:0] r_reqAddr;

    logic               w_push;
    logic               w_pop;
    logic [M_WIDTH-1:0] w_flushAligned;

    // A push needs a live request completing with no redirect in the same
    // cycle; a redirect also cancels any pop, so flush wins over both.
    assign w_push = (r_state == REQ) && i_mem_ready && !i_flush;
    assign w_pop  = i_inst_take && (r_count != '0) && !i_flush;

    // Redirect targets are forced onto a word boundary.
    assign w_flushAligned = i_flush_pc & ~(M_WIDTH'(3));

    // State register of the fetch FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A single request is outstanding at most, and IDLE
    // always sits between two requests so mem_req drops for a cycle. A
    // completion in REQ or DRAIN always returns to IDLE; a redirect that
    // arrives before the data turns REQ into DRAIN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!i_flush && (r_count < FULL_COUNT)) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    w_nextState = IDLE;
                end else if (i_flush) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (i_mem_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs. While a request is live the address comes from the copy
    // latched when the request was issued. In DRAIN, fetch_addr already holds
    // the redirect target, but the bus must keep showing the old address.
    always_comb begin
        o_mem_req  = (r_state != IDLE);
        o_mem_addr = (r_state == IDLE) ? r_fetchAddr : r_reqAddr;
    end

    // Queue pointers, occupancy and fetch address.
    // r_reqAddr tracks fetch_addr every IDLE cycle. It is therefore frozen at
    // the address of the request for as long as that request is outstanding.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_fetchAddr <= RESET_PC;
            r_reqAddr   <= RESET_PC;
        end else begin
            if (r_state == IDLE) begin
                r_reqAddr <= r_fetchAddr;
            end
            if (i_flush) begin
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                r_fetchAddr <= w_flushAligned;
            end else begin
                if (w_push) begin
                    r_tail      <= r_tail + PTR_W'(1);
                    r_fetchAddr <= r_fetchAddr + WORD_STEP;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage has no reset; an empty queue never exposes its contents
    // as valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pcMem[r_tail]   <= r_fetchAddr;
            r_instMem[r_tail] <= i_mem_data_in;
        end
    end

    assign o_inst_valid = (r_count != '0);
    assign o_inst_out   = r_instMem[r_head];
    assign o_inst_pc    = r_pcMem[r_head];

endmodule
